tcdm_cmd_split: RTL and testbench
=================================

# tcdm_cmd_split

Command splitter directly upstream of `tcdm_unit`. It accepts one linear TCDM transfer command of up to 2^MCHAN_LEN_WIDTH bytes and breaks it into chunks that never cross a 2^TCDM_BURST_WIDTH-byte address boundary. It routes each chunk to the TX command port (TCDM read) or the RX command port (TCDM write) according to the opcode. Each emitted chunk is a complete command for `tcdm_unit`, so every chunk produces one synch event downstream.

## Interface
- TRANS_SID_WIDTH, 1, transfer stream ID width
- TCDM_ADD_WIDTH, 12, TCDM byte address width
- TCDM_OPC_WIDTH, 12, opcode width; bit 0 = 1 means TCDM read (TX), bit 0 = 0 means TCDM write (RX)
- MCHAN_LEN_WIDTH, 15, length field width; encoding is byte count minus 1
- TCDM_BURST_WIDTH, 7, log2 of the chunk boundary in bytes; must be <= MCHAN_LEN_WIDTH and <= TCDM_ADD_WIDTH

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, asynchronous, active-low
- cmd_sid_i  in  TRANS_SID_WIDTH  command stream ID
- cmd_add_i  in  TCDM_ADD_WIDTH  start byte address
- cmd_opc_i  in  TCDM_OPC_WIDTH  opcode
- cmd_len_i  in  MCHAN_LEN_WIDTH  byte count minus 1
- cmd_req_i  in  1  command valid
- cmd_gnt_o  out  1  command accepted
- tcdm_tx_sid_o / tcdm_tx_add_o / tcdm_tx_opc_o / tcdm_tx_len_o  out  same widths as cmd_*  TX chunk payload
- tcdm_tx_req_o  out  1  TX chunk valid
- tcdm_tx_gnt_i  in  1  TX chunk accepted
- tcdm_rx_sid_o / tcdm_rx_add_o / tcdm_rx_opc_o / tcdm_rx_len_o  out  same widths as cmd_*  RX chunk payload
- tcdm_rx_req_o  out  1  RX chunk valid
- tcdm_rx_gnt_i  in  1  RX chunk accepted
- busy_o  out  1  high while a command is being split

## Operation
- FSM with two states, IDLE and SPLIT. Reset state is IDLE.
- IDLE:
  - cmd_gnt_o = 1.
  - On cmd_req_i, register sid, opc, add into cur_add, and rem = cmd_len_i + 1. rem is MCHAN_LEN_WIDTH+1 bits wide.
  - dir = cmd_opc_i[0]. Transition to SPLIT.
- SPLIT:
  - cmd_gnt_o = 0.
  - room = 2^TCDM_BURST_WIDTH − cur_add[TCDM_BURST_WIDTH-1:0].
  - chunk = min(rem, room).
  - The selected port drives req = 1, add = cur_add, len = chunk − 1, sid and opc registered.
  - Selected port is TX when dir = 1, RX when dir = 0. The other port's req stays 0.
- On grant of the selected port:
  - cur_add += chunk, modulo 2^TCDM_ADD_WIDTH (wrap-around is allowed and silent).
  - rem −= chunk.
  - If chunk == rem (last chunk), go to IDLE; otherwise stay in SPLIT.
- A grant on the unselected port, or any grant in IDLE, is ignored.
- busy_o = (state == SPLIT).
- Payload outputs of a port with req = 0 hold their last value and are don't-care. The bench checks them only while req = 1.
- Reset asserted mid-transfer: FSM returns to IDLE immediately, every req output drops to 0, and the in-flight command is discarded with no further chunks.

## Timing
- Reset values:
  - cmd_gnt_o = 1 and busy_o = 0.
  - tcdm_tx_req_o = tcdm_rx_req_o = 0.
  - All payload outputs = 0.
- Command accepted in cycle N (cmd_req_i & cmd_gnt_o at the rising edge) → first chunk req = 1 in cycle N+1.
- Req/payload stability: once req = 1, req and payload remain constant until the cycle where gnt = 1. Req never drops without a grant.
- Chunk throughput: with gnt held at 1, one chunk per cycle. Back-to-back chunks keep req = 1 continuously, with the payload updating on the cycle after each grant.
- After the last chunk is granted in cycle M, the FSM is in IDLE in cycle M+1 and can accept the next command then. The next first chunk appears at M+2, giving one idle cycle between commands.
- A command of k chunks with gnt always high occupies the block for k cycles in SPLIT.
- Payload outputs are driven from registers and combinational logic on registers only. There is no combinational path from cmd_* or gnt inputs to req or payload outputs.

## Test plan
- Single aligned chunk:
  - Stimulus: RX command, add 0x080, len 0x07F, burst 128, gnt always high.
  - Response: one RX chunk, add 0x080 / len 0x07F, in cycle N+1; busy_o high for exactly 1 cycle; tcdm_tx_req_o never high.
- Three-way split:
  - Stimulus: TX command, add 0x07C, len 0x0FF, gnt always high.
  - Response: TX chunks (0x07C, 0x003), (0x080, 0x07F), (0x100, 0x07B) in consecutive cycles; sid and opc equal the input on every chunk.
- Backpressure:
  - Stimulus: same command as the three-way split, with tcdm_tx_gnt_i low for 5 cycles before each grant.
  - Response: each chunk's req/payload held constant through every stall; the same three chunks appear in order.
- Address wrap:
  - Stimulus: RX command, add 0xFF0, len 0x01F.
  - Response: chunks (0xFF0, 0x00F) then (0x000, 0x00F).
- Maximum length and reset:
  - Stimulus: TX command, add 0x000, len 0x7FFF; after the 3rd chunk grant, assert rst_ni low for 1 cycle.
  - Response: the first 3 chunks are (0x000, 0x07F), (0x080, 0x07F), (0x100, 0x07F). Once reset is asserted, req = 0 and cmd_gnt_o = 1 immediately. No further chunks are emitted.
- Back-to-back commands:
  - Stimulus: command A (TX, 0x000, len 0x003) immediately followed by command B (RX, 0x010, len 0x007).
  - Response: A is accepted at cycle N and its TX chunk appears at N+1. B is accepted at cycle N+2 and its RX chunk appears at N+3.

Source files
------------

// File: rtl/tcdm_cmd_split.sv
// Splits one linear TCDM command into chunks that never cross a 2^TCDM_BURST_WIDTH-byte boundary.
// Latency: first chunk valid the cycle after command accept; one chunk per cycle while granted.
// Backpressure: chunk req/payload held until the selected port grants; cmd_gnt_o low while splitting.
module tcdm_cmd_split #(
  parameter int TRANS_SID_WIDTH  = 1,
  parameter int TCDM_ADD_WIDTH   = 12,
  parameter int TCDM_OPC_WIDTH   = 12,
  parameter int MCHAN_LEN_WIDTH  = 15,
  parameter int TCDM_BURST_WIDTH = 7
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [TRANS_SID_WIDTH-1:0]  cmd_sid_i,
  input  logic [TCDM_ADD_WIDTH-1:0]   cmd_add_i,
  input  logic [TCDM_OPC_WIDTH-1:0]   cmd_opc_i,
  input  logic [MCHAN_LEN_WIDTH-1:0]  cmd_len_i,
  input  logic                        cmd_req_i,
  output logic                        cmd_gnt_o,
  output logic [TRANS_SID_WIDTH-1:0]  tcdm_tx_sid_o,
  output logic [TCDM_ADD_WIDTH-1:0]   tcdm_tx_add_o,
  output logic [TCDM_OPC_WIDTH-1:0]   tcdm_tx_opc_o,
  output logic [MCHAN_LEN_WIDTH-1:0]  tcdm_tx_len_o,
  output logic                        tcdm_tx_req_o,
  input  logic                        tcdm_tx_gnt_i,
  output logic [TRANS_SID_WIDTH-1:0]  tcdm_rx_sid_o,
  output logic [TCDM_ADD_WIDTH-1:0]   tcdm_rx_add_o,
  output logic [TCDM_OPC_WIDTH-1:0]   tcdm_rx_opc_o,
  output logic [MCHAN_LEN_WIDTH-1:0]  tcdm_rx_len_o,
  output logic                        tcdm_rx_req_o,
  input  logic                        tcdm_rx_gnt_i,
  output logic                        busy_o
);

  // Remaining byte count needs one extra bit: a full-length command is 2^MCHAN_LEN_WIDTH bytes.
  localparam int RW = MCHAN_LEN_WIDTH + 1;
  localparam logic [TCDM_BURST_WIDTH:0] BURST_BYTES = {1'b1, {TCDM_BURST_WIDTH{1'b0}}};

  typedef enum logic {IDLE, SPLIT} state_e;

  state_e                      state_q, state_d;
  logic [TRANS_SID_WIDTH-1:0]  sid_q, sid_d;
  logic [TCDM_OPC_WIDTH-1:0]   opc_q, opc_d;
  logic [TCDM_ADD_WIDTH-1:0]   cur_add_q, cur_add_d;
  logic [RW-1:0]               rem_q, rem_d;
  logic                        dir_q, dir_d;

  logic [TCDM_BURST_WIDTH:0]   room, chunk;
  logic [RW-1:0]               room_ext, chunk_ext;
  logic                        last, busy, sel_gnt;
  logic [MCHAN_LEN_WIDTH-1:0]  len_out;

  // Current chunk size: bytes left, clipped to the distance to the next burst boundary.
  always_comb begin
    room      = BURST_BYTES - {1'b0, cur_add_q[TCDM_BURST_WIDTH-1:0]};
    room_ext  = RW'(room);
    chunk_ext = (rem_q < room_ext) ? rem_q : room_ext;
    chunk     = (TCDM_BURST_WIDTH+1)'(chunk_ext);
    last      = (rem_q == chunk_ext);
  end

  // Next-state logic: load a command in IDLE, advance address/remainder on each chunk grant.
  always_comb begin
    state_d   = state_q;
    sid_d     = sid_q;
    opc_d     = opc_q;
    cur_add_d = cur_add_q;
    rem_d     = rem_q;
    dir_d     = dir_q;
    cmd_gnt_o = 1'b0;
    sel_gnt   = dir_q ? tcdm_tx_gnt_i : tcdm_rx_gnt_i;
    case (state_q)
      IDLE: begin
        cmd_gnt_o = 1'b1;
        if (cmd_req_i) begin
          sid_d     = cmd_sid_i;
          opc_d     = cmd_opc_i;
          cur_add_d = cmd_add_i;
          rem_d     = {1'b0, cmd_len_i} + RW'(1);
          dir_d     = cmd_opc_i[0];
          state_d   = SPLIT;
        end
      end
      SPLIT: begin
        if (sel_gnt) begin
          cur_add_d = cur_add_q + TCDM_ADD_WIDTH'(chunk);
          rem_d     = rem_q - chunk_ext;
          if (last) state_d = IDLE;
        end
      end
    endcase
  end

  // State and command registers; reset discards any in-flight command.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      sid_q     <= '0;
      opc_q     <= '0;
      cur_add_q <= '0;
      rem_q     <= '0;
      dir_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sid_q     <= sid_d;
      opc_q     <= opc_d;
      cur_add_q <= cur_add_d;
      rem_q     <= rem_d;
      dir_q     <= dir_d;
    end
  end

  // Outputs depend only on registers; length is forced to zero outside SPLIT.
  always_comb begin
    busy          = (state_q == SPLIT);
    len_out       = busy ? MCHAN_LEN_WIDTH'(chunk - 1'b1) : '0;
    busy_o        = busy;
    tcdm_tx_req_o = busy & dir_q;
    tcdm_rx_req_o = busy & ~dir_q;
    tcdm_tx_sid_o = sid_q;
    tcdm_tx_add_o = cur_add_q;
    tcdm_tx_opc_o = opc_q;
    tcdm_tx_len_o = len_out;
    tcdm_rx_sid_o = sid_q;
    tcdm_rx_add_o = cur_add_q;
    tcdm_rx_opc_o = opc_q;
    tcdm_rx_len_o = len_out;
  end

endmodule

// File: tb/tb_tcdm_cmd_split.sv
// Directed bench for tcdm_cmd_split: vector table of commands with expected chunk lists,
// plus hand-written sequences for backpressure, mid-transfer reset and back-to-back commands.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_tcdm_cmd_split;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_sid;
  logic [11:0] cmd_add;
  logic [11:0] cmd_opc;
  logic [14:0] cmd_len;
  logic        cmd_req;
  logic        cmd_gnt;
  logic        tx_sid, rx_sid;
  logic [11:0] tx_add, rx_add, tx_opc, rx_opc;
  logic [14:0] tx_len, rx_len;
  logic        tx_req, rx_req, tx_gnt, rx_gnt;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tcdm_cmd_split dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_sid_i(cmd_sid), .cmd_add_i(cmd_add), .cmd_opc_i(cmd_opc), .cmd_len_i(cmd_len),
    .cmd_req_i(cmd_req), .cmd_gnt_o(cmd_gnt),
    .tcdm_tx_sid_o(tx_sid), .tcdm_tx_add_o(tx_add), .tcdm_tx_opc_o(tx_opc), .tcdm_tx_len_o(tx_len),
    .tcdm_tx_req_o(tx_req), .tcdm_tx_gnt_i(tx_gnt),
    .tcdm_rx_sid_o(rx_sid), .tcdm_rx_add_o(rx_add), .tcdm_rx_opc_o(rx_opc), .tcdm_rx_len_o(rx_len),
    .tcdm_rx_req_o(rx_req), .tcdm_rx_gnt_i(rx_gnt),
    .busy_o(busy)
  );

  typedef struct packed {
    logic             tx;
    logic             sid;
    logic [11:0]      opc;
    logic [11:0]      add;
    logic [14:0]      len;
    int               n;
    logic [3:0][11:0] cadd;
    logic [3:0][14:0] clen;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare the selected port against one expected chunk; the other port must stay idle.
  task automatic check_chunk(input vec_t v, input int i);
    string tag;
    tag = $sformatf("chunk%0d", i);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_cmd_gnt"}, 32'(cmd_gnt), 32'd0);
    if (v.tx) begin
      chk({tag, "_tx_req"}, 32'(tx_req), 32'd1);
      chk({tag, "_rx_req"}, 32'(rx_req), 32'd0);
      chk({tag, "_tx_add"}, 32'(tx_add), 32'(v.cadd[i]));
      chk({tag, "_tx_len"}, 32'(tx_len), 32'(v.clen[i]));
      chk({tag, "_tx_sid"}, 32'(tx_sid), 32'(v.sid));
      chk({tag, "_tx_opc"}, 32'(tx_opc), 32'(v.opc));
    end else begin
      chk({tag, "_rx_req"}, 32'(rx_req), 32'd1);
      chk({tag, "_tx_req"}, 32'(tx_req), 32'd0);
      chk({tag, "_rx_add"}, 32'(rx_add), 32'(v.cadd[i]));
      chk({tag, "_rx_len"}, 32'(rx_len), 32'(v.clen[i]));
      chk({tag, "_rx_sid"}, 32'(rx_sid), 32'(v.sid));
      chk({tag, "_rx_opc"}, 32'(rx_opc), 32'(v.opc));
    end
  endtask

  // Issue one command, then walk its chunks; 'stall' low-grant cycles precede every grant,
  // during which the unselected port is granted to show that grant is ignored.
  task automatic run_vec(input vec_t v, input int stall);
    cmd_sid = v.sid; cmd_add = v.add; cmd_opc = v.opc; cmd_len = v.len;
    cmd_req = 1'b1;
    tx_gnt  = (stall == 0);
    rx_gnt  = (stall == 0);
    chk("accept_cmd_gnt", 32'(cmd_gnt), 32'd1);
    @(negedge clk);
    cmd_req = 1'b0;
    for (int i = 0; i < v.n; i++) begin
      for (int s = 0; s < stall; s++) begin
        tx_gnt = ~v.tx;
        rx_gnt = v.tx;
        check_chunk(v, i);
        @(negedge clk);
      end
      tx_gnt = 1'b1;
      rx_gnt = 1'b1;
      check_chunk(v, i);
      @(negedge clk);
    end
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_cmd_gnt", 32'(cmd_gnt), 32'd1);
    chk("done_tx_req", 32'(tx_req), 32'd0);
    chk("done_rx_req", 32'(rx_req), 32'd0);
  endtask

  initial begin
    // tx sid opc add len n chunk adds / lens (index 0 is the first chunk)
    vecs[0] = '{tx:1'b0, sid:1'b0, opc:12'h010, add:12'h080, len:15'h007F, n:1,
                cadd:{12'h0, 12'h0, 12'h0, 12'h080}, clen:{15'h0, 15'h0, 15'h0, 15'h07F}};
    vecs[1] = '{tx:1'b1, sid:1'b1, opc:12'h0A5, add:12'h07C, len:15'h00FF, n:3,
                cadd:{12'h0, 12'h100, 12'h080, 12'h07C}, clen:{15'h0, 15'h07B, 15'h07F, 15'h003}};
    vecs[2] = '{tx:1'b0, sid:1'b0, opc:12'h002, add:12'hFF0, len:15'h001F, n:2,
                cadd:{12'h0, 12'h0, 12'h000, 12'hFF0}, clen:{15'h0, 15'h0, 15'h00F, 15'h00F}};
    vecs[3] = '{tx:1'b1, sid:1'b1, opc:12'h3C1, add:12'h7F3, len:15'h0004, n:1,
                cadd:{12'h0, 12'h0, 12'h0, 12'h7F3}, clen:{15'h0, 15'h0, 15'h0, 15'h004}};

    rst_n = 1'b0; cmd_req = 1'b0; cmd_sid = 1'b0; cmd_add = '0; cmd_opc = '0; cmd_len = '0;
    tx_gnt = 1'b0; rx_gnt = 1'b0;
    @(negedge clk);
    chk("rst_cmd_gnt", 32'(cmd_gnt), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_req", 32'(tx_req), 32'd0);
    chk("rst_rx_req", 32'(rx_req), 32'd0);
    chk("rst_tx_payload", {tx_add, tx_opc, 7'(tx_len), tx_sid}, 32'd0);
    chk("rst_rx_payload", {rx_add, rx_opc, 7'(rx_len), rx_sid}, 32'd0);
    chk("rst_lens", {2'b0, tx_len, rx_len}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven commands with grant held high.
    for (int k = 0; k < 4; k++) begin
      run_vec(vecs[k], 0);
      @(negedge clk);
    end

    // Backpressure: three-way split with 5 stall cycles before each grant.
    run_vec(vecs[1], 5);
    @(negedge clk);

    // Maximum length, reset after the third chunk grant.
    cmd_sid = 1'b1; cmd_add = 12'h000; cmd_opc = 12'h001; cmd_len = 15'h7FFF;
    cmd_req = 1'b1; tx_gnt = 1'b1; rx_gnt = 1'b1;
    chk("max_accept", 32'(cmd_gnt), 32'd1);
    @(negedge clk);
    cmd_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("max%0d_tx_req", i), 32'(tx_req), 32'd1);
      chk($sformatf("max%0d_tx_add", i), 32'(tx_add), 32'(12'h080 * i));
      chk($sformatf("max%0d_tx_len", i), 32'(tx_len), 32'h07F);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_req", 32'(tx_req), 32'd0);
    chk("midrst_rx_req", 32'(rx_req), 32'd0);
    chk("midrst_cmd_gnt", 32'(cmd_gnt), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("postrst_req", {30'd0, tx_req, rx_req}, 32'd0);
    end

    // Back-to-back: A (TX 0x000 len 3) then B (RX 0x010 len 7) presented immediately.
    cmd_sid = 1'b0; cmd_add = 12'h000; cmd_opc = 12'h0F1; cmd_len = 15'h0003;
    cmd_req = 1'b1; tx_gnt = 1'b1; rx_gnt = 1'b1;
    chk("b2b_a_accept", 32'(cmd_gnt), 32'd1);
    @(negedge clk);
    chk("b2b_a_tx_req", 32'(tx_req), 32'd1);
    chk("b2b_a_tx_add", 32'(tx_add), 32'h000);
    chk("b2b_a_tx_len", 32'(tx_len), 32'h003);
    chk("b2b_a_cmd_gnt", 32'(cmd_gnt), 32'd0);
    cmd_sid = 1'b1; cmd_add = 12'h010; cmd_opc = 12'h0F0; cmd_len = 15'h0007;
    @(negedge clk);
    chk("b2b_gap_cmd_gnt", 32'(cmd_gnt), 32'd1);
    chk("b2b_gap_req", {30'd0, tx_req, rx_req}, 32'd0);
    @(negedge clk);
    cmd_req = 1'b0;
    chk("b2b_b_rx_req", 32'(rx_req), 32'd1);
    chk("b2b_b_tx_req", 32'(tx_req), 32'd0);
    chk("b2b_b_rx_add", 32'(rx_add), 32'h010);
    chk("b2b_b_rx_len", 32'(rx_len), 32'h007);
    chk("b2b_b_rx_sid", 32'(rx_sid), 32'd1);
    chk("b2b_b_rx_opc", 32'(rx_opc), 32'h0F0);
    @(negedge clk);
    chk("b2b_done_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
